// File: rtl/river_pkg.sv
// river_pkg
// Shared definitions for the river scroll controller:
//   - river geometry constants (centre column, left oscillation, width)
//   - query FSM state encoding
//   - computeEdges(): turns a 6-bit ROM offset into left/right bank columns
package river_pkg;

  localparam int unsigned STREAM_CENTER = 250;
  localparam int unsigned STREAM_OSC    = 30;
  localparam int unsigned STREAM_WIDTH  = 63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    Q_ADDR = 2'd1,
    Q_WAIT = 2'd2,
    Q_DONE = 2'd3
  } query_state_e;

  typedef struct packed {
    logic [9:0] left;
    logic [9:0] right;
  } edges_t;

  // Offset range 0..63 keeps left in 220..283 and right in 283..346,
  // so 10-bit arithmetic never wraps.
  function automatic edges_t computeEdges(input logic [5:0] offset);
    edges_t e;
    e.left  = 10'(STREAM_CENTER - STREAM_OSC) + {4'd0, offset};
    e.right = e.left + 10'(STREAM_WIDTH);
    return e;
  endfunction

endpackage

// File: rtl/river_query_fsm.sv
// river_query_fsm
// Serves "where are the banks at row y?" queries from the collision logic,
// borrowing the offset ROM only while video is blanked.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   videoOn_i          active video; a query is only started/continued in blanking
//   qReq_i, qY_i       request level and query row (row sampled on acceptance)
//   romData_i          offset ROM data, one cycle after the address
//   qSel_o             steers the ROM address mux to the query row
//   qAddrY_o           captured query row (low 8 bits feed the ROM address)
//   qAck_o             one-cycle acknowledge
//   qLeft_o, qRight_o  query result edges, held after the acknowledge
module river_query_fsm
  import river_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       videoOn_i,
  input  logic       qReq_i,
  input  logic [9:0] qY_i,
  input  logic [5:0] romData_i,
  output logic       qSel_o,
  output logic [7:0] qAddrY_o,
  output logic       qAck_o,
  output logic [9:0] qLeft_o,
  output logic [9:0] qRight_o
);

  query_state_e state_q, state_d;
  logic [7:0]   qY_q;
  edges_t       qEdges_q;
  edges_t       romEdges;
  logic         unusedQyHigh;

  // The ROM only has 256 rows, so the upper query-row bits never matter.
  assign unusedQyHigh = ^qY_i[9:8];
  assign romEdges     = computeEdges(romData_i);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: any return of active video while the ROM is borrowed
  // abandons the query; the requester keeps q_req high and it is retried.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (qReq_i && !videoOn_i) state_d = Q_ADDR;
      Q_ADDR:  state_d = videoOn_i ? IDLE : Q_WAIT;
      Q_WAIT:  state_d = videoOn_i ? IDLE : Q_DONE;
      Q_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    qSel_o = (state_q == Q_ADDR);
    qAck_o = (state_q == Q_DONE);
  end

  // Query row is latched on acceptance; ROM data is captured in Q_WAIT, the
  // cycle after the query row was presented to the ROM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qY_q     <= '0;
      qEdges_q <= '0;
    end else begin
      if (state_q == IDLE && qReq_i && !videoOn_i) qY_q <= qY_i[7:0];
      if (state_q == Q_WAIT) qEdges_q <= romEdges;
    end
  end

  assign qAddrY_o = qY_q;
  assign qLeft_o  = qEdges_q.left;
  assign qRight_o = qEdges_q.right;

endmodule

// File: rtl/river_scroll_ctrl.sv
// river_scroll_ctrl
// Owns the river-offset ROM: advances the per-frame scroll, addresses the
// ROM for the raster renderer, and lends it to the query FSM during blanking.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   videoOn_i, pixelX_i, pixelY_i raster position from vga_sync
//   speed_i, pause_i              rows scrolled per frame, scroll freeze
//   romAddr_o, romData_i          offset ROM (1-cycle synchronous read)
//   qReq_i, qY_i, qAck_o,
//   qLeft_o, qRight_o             edge-query handshake
//   leftEdge_o, rightEdge_o,
//   inRiver_o                     registered render-path results
//   scroll_o, frameTick_o         scroll position, frame-start pulse
module river_scroll_ctrl
  import river_pkg::*;
#(
  parameter int unsigned SPEED_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               videoOn_i,
  input  logic [9:0]         pixelX_i,
  input  logic [9:0]         pixelY_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic               pause_i,
  output logic [7:0]         romAddr_o,
  input  logic [5:0]         romData_i,
  input  logic               qReq_i,
  input  logic [9:0]         qY_i,
  output logic               qAck_o,
  output logic [9:0]         qLeft_o,
  output logic [9:0]         qRight_o,
  output logic [9:0]         leftEdge_o,
  output logic [9:0]         rightEdge_o,
  output logic               inRiver_o,
  output logic [7:0]         scroll_o,
  output logic               frameTick_o
);

  logic [9:0] prevY_q;
  logic [7:0] scroll_q, scroll_d;
  logic [9:0] pixelXDly_q;
  logic [9:0] leftEdge_q, rightEdge_q;
  logic       inRiver_q;
  logic       frameTick;
  logic       qSel;
  logic [7:0] qAddrY;
  edges_t     renderEdges;

  river_query_fsm u_query (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .videoOn_i (videoOn_i),
    .qReq_i    (qReq_i),
    .qY_i      (qY_i),
    .romData_i (romData_i),
    .qSel_o    (qSel),
    .qAddrY_o  (qAddrY),
    .qAck_o    (qAck_o),
    .qLeft_o   (qLeft_o),
    .qRight_o  (qRight_o)
  );

  // A frame starts on the first cycle the raster is back on row 0.
  assign frameTick = (pixelY_i == 10'd0) && (prevY_q != 10'd0);

  // Scroll moves upward through the ROM by 'speed' rows per frame, wrapping.
  always_comb begin
    scroll_d = scroll_q;
    if (frameTick && !pause_i) scroll_d = scroll_q - 8'(speed_i);
  end

  // Frame detector and scroll registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prevY_q  <= '0;
      scroll_q <= '0;
    end else begin
      prevY_q  <= pixelY_i;
      scroll_q <= scroll_d;
    end
  end

  assign romAddr_o   = (qSel ? qAddrY : pixelY_i[7:0]) + scroll_q;
  assign renderEdges = computeEdges(romData_i);

  // Render stage 2. pixel_x is delayed one register here so that, together
  // with the ROM cycle, in_river lines up with the pixel from two clocks ago.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pixelXDly_q <= '0;
      leftEdge_q  <= '0;
      rightEdge_q <= '0;
      inRiver_q   <= 1'b0;
    end else begin
      pixelXDly_q <= pixelX_i;
      leftEdge_q  <= renderEdges.left;
      rightEdge_q <= renderEdges.right;
      inRiver_q   <= (pixelXDly_q >= renderEdges.left) &&
                     (pixelXDly_q <= renderEdges.right);
    end
  end

  assign leftEdge_o  = leftEdge_q;
  assign rightEdge_o = rightEdge_q;
  assign inRiver_o   = inRiver_q;
  assign scroll_o    = scroll_q;
  assign frameTick_o = frameTick;

endmodule

// File: tb/tb_river_scroll_ctrl.sv
// tb_river_scroll_ctrl
// Bench for river_scroll_ctrl with an offset ROM whose data is addr[5:0].
// A per-cycle reference model (scroll arithmetic and edge formula) runs on the
// falling edge; directed scenarios add literal expectations.
module tb_river_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       videoOn;
  logic [9:0] pixelX;
  logic [9:0] pixelY;
  logic [2:0] speed;
  logic       pause;
  logic [7:0] romAddr;
  logic [5:0] romData = 6'd0;
  logic       qReq;
  logic [9:0] qY;
  logic       qAck;
  logic [9:0] qLeft, qRight;
  logic [9:0] leftEdge, rightEdge;
  logic       inRiver;
  logic [7:0] scroll;
  logic       frameTick;

  int testsRun = 0;
  int testsFailed = 0;

  int mScroll = 0;
  int mPrevY = 0;
  int hY[4];
  int hX[4];
  int hS[4];
  bit hVo[4];
  bit hValid[4];
  int mAddr, mOff, mLeft, mRight, mIn, mSpeed;
  bit mTick;

  int cyc;
  bit got;
  int ackSeen;

  river_scroll_ctrl #(.SPEED_W(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .videoOn_i   (videoOn),
    .pixelX_i    (pixelX),
    .pixelY_i    (pixelY),
    .speed_i     (speed),
    .pause_i     (pause),
    .romAddr_o   (romAddr),
    .romData_i   (romData),
    .qReq_i      (qReq),
    .qY_i        (qY),
    .qAck_o      (qAck),
    .qLeft_o     (qLeft),
    .qRight_o    (qRight),
    .leftEdge_o  (leftEdge),
    .rightEdge_o (rightEdge),
    .inRiver_o   (inRiver),
    .scroll_o    (scroll),
    .frameTick_o (frameTick)
  );

  always #5 clk = ~clk;

  // Offset ROM: one-cycle synchronous read, content = low six address bits.
  always @(posedge clk) romData <= romAddr[5:0];

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change just after a rising edge, then n cycles elapse.
  task automatic applyStimulus(input int y, input int x, input bit vo, input int n);
    pixelY  = 10'(y);
    pixelX  = 10'(x);
    videoOn = vo;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input int n);
    int cols[8] = '{225, 229, 230, 260, 283, 284, 294, 300};
    for (int f = 0; f < n; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 8; c++)
          applyStimulus(r, cols[c], (r < 8), 2);
  endtask

  // Counts rising edges until q_ack is seen (sampled on the falling edge).
  task automatic waitAck(input int maxCyc, output int n, output bit seen);
    n = 0;
    seen = 0;
    while (!seen && n < maxCyc) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (qAck) seen = 1;
    end
  endtask

  function automatic int expLeftFor(input int row, input int scr);
    return 220 + (((row % 256) + scr) % 256) % 64;
  endfunction

  // Reference model: frame start, scroll and render edges, every cycle.
  always @(negedge clk) begin
    if (!rstN) begin
      mScroll = 0;
      mPrevY  = 0;
      for (int i = 0; i < 4; i++) hValid[i] = 0;
    end else begin
      for (int i = 3; i > 0; i--) begin
        hY[i] = hY[i-1];
        hX[i] = hX[i-1];
        hS[i] = hS[i-1];
        hVo[i] = hVo[i-1];
        hValid[i] = hValid[i-1];
      end
      hY[0] = int'(pixelY);
      hX[0] = int'(pixelX);
      hS[0] = mScroll;
      hVo[0] = videoOn;
      hValid[0] = 1;
      mTick = (pixelY == 0) && (mPrevY != 0);
      checkOutput("frame_tick", int'(frameTick), int'(mTick));
      checkOutput("scroll", int'(scroll), mScroll);
      if (hValid[1] && hValid[2] && hValid[3] && hVo[2] && hVo[3]) begin
        mAddr  = ((hY[2] % 256) + hS[2]) % 256;
        mOff   = mAddr % 64;
        mLeft  = 220 + mOff;
        mRight = mLeft + 63;
        mIn    = (hX[2] >= mLeft && hX[2] <= mRight) ? 1 : 0;
        checkOutput("render_left", int'(leftEdge), mLeft);
        checkOutput("render_right", int'(rightEdge), mRight);
        checkOutput("render_in_river", int'(inRiver), mIn);
      end
      mSpeed = int'(speed);
      if (mTick && !pause) mScroll = (mScroll - mSpeed + 256) % 256;
      mPrevY = int'(pixelY);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; videoOn = 1'b0; pixelX = '0; pixelY = 10'd37;
    speed = '0; pause = 1'b0; qReq = 1'b0; qY = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_scroll", int'(scroll), 0);
    checkOutput("rst_frame_tick", int'(frameTick), 0);
    checkOutput("rst_q_ack", int'(qAck), 0);
    checkOutput("rst_q_left", int'(qLeft), 0);
    checkOutput("rst_q_right", int'(qRight), 0);
    checkOutput("rst_left_edge", int'(leftEdge), 0);
    checkOutput("rst_right_edge", int'(rightEdge), 0);
    checkOutput("rst_in_river", int'(inRiver), 0);
    checkOutput("rst_rom_addr", int'(romAddr), 37);
    @(posedge clk);
    #1 rstN = 1'b1;

    // Render at row 10, scroll 0: banks at 230..293, inclusive bounds.
    applyStimulus(10, 229, 1, 2);
    checkOutput("lit_left", int'(leftEdge), 230);
    checkOutput("lit_right", int'(rightEdge), 293);
    checkOutput("lit_in_229", int'(inRiver), 0);
    applyStimulus(10, 230, 1, 2);
    checkOutput("lit_in_230", int'(inRiver), 1);
    applyStimulus(10, 293, 1, 2);
    checkOutput("lit_in_293", int'(inRiver), 1);
    applyStimulus(10, 294, 1, 2);
    checkOutput("lit_in_294", int'(inRiver), 0);

    // Scroll by 3 per frame.
    speed = 3'd3;
    runFrame(1);
    checkOutput("lit_scroll_tick1", int'(scroll), 253);
    runFrame(1);
    checkOutput("lit_scroll_tick2", int'(scroll), 250);

    // Pause and zero speed both freeze the scroll.
    pause = 1'b1;
    runFrame(3);
    checkOutput("lit_scroll_pause", int'(scroll), 250);
    pause = 1'b0;
    speed = 3'd0;
    runFrame(2);
    checkOutput("lit_scroll_speed0", int'(scroll), 250);

    // Bring scroll to 5 (250 - 35*7).
    speed = 3'd7;
    runFrame(35);
    checkOutput("lit_scroll_5", int'(scroll), 5);

    // Query in blanking: row 100 + scroll 5 -> offset 41 -> 261/324.
    applyStimulus(9, 0, 0, 2);
    qY = 10'd100;
    qReq = 1'b1;
    @(posedge clk);
    #1 qY = 10'd3;
    waitAck(20, cyc, got);
    checkOutput("query_acked", int'(got), 1);
    checkOutput("query_latency", cyc + 1, 3);
    checkOutput("query_left", int'(qLeft), 261);
    checkOutput("query_right", int'(qRight), 324);
    checkOutput("query_left_model", int'(qLeft), expLeftFor(100, mScroll));
    @(posedge clk);
    #1 qReq = 1'b0;
    checkOutput("query_ack_pulse", int'(qAck), 0);
    checkOutput("query_left_held", int'(qLeft), 261);
    checkOutput("query_right_held", int'(qRight), 324);

    // Wraparound: 5 -> 2 -> 255.
    speed = 3'd3;
    runFrame(1);
    checkOutput("lit_scroll_2", int'(scroll), 2);
    runFrame(1);
    checkOutput("lit_scroll_wrap", int'(scroll), 255);

    // Video returns during Q_WAIT: no ack, retried in the next blanking.
    applyStimulus(9, 0, 0, 1);
    qY = 10'd7;
    qReq = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 videoOn = 1'b1;
    ackSeen = 0;
    repeat (6) begin
      @(negedge clk);
      if (qAck) ackSeen++;
      checkOutput("abort_rom_addr", int'(romAddr), (9 + mScroll) % 256);
    end
    checkOutput("abort_no_ack", ackSeen, 0);
    @(posedge clk);
    #1 videoOn = 1'b0;
    waitAck(20, cyc, got);
    checkOutput("retry_acked", int'(got), 1);
    checkOutput("retry_latency", cyc, 3);
    checkOutput("retry_left", int'(qLeft), 226);
    checkOutput("retry_right", int'(qRight), 289);
    checkOutput("retry_left_model", int'(qLeft), expLeftFor(7, mScroll));
    @(posedge clk);
    #1 qReq = 1'b0;

    // Reset while in Q_ADDR: everything clears, no ack, re-request completes.
    applyStimulus(9, 0, 0, 1);
    qY = 10'd50;
    qReq = 1'b1;
    @(posedge clk);
    #1 rstN = 1'b0;
    @(negedge clk);
    checkOutput("midrst_scroll", int'(scroll), 0);
    checkOutput("midrst_q_left", int'(qLeft), 0);
    checkOutput("midrst_q_right", int'(qRight), 0);
    checkOutput("midrst_left_edge", int'(leftEdge), 0);
    checkOutput("midrst_right_edge", int'(rightEdge), 0);
    checkOutput("midrst_in_river", int'(inRiver), 0);
    checkOutput("midrst_rom_addr", int'(romAddr), 9);
    ackSeen = int'(qAck);
    repeat (3) begin
      @(negedge clk);
      if (qAck) ackSeen++;
    end
    checkOutput("midrst_no_ack", ackSeen, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    waitAck(20, cyc, got);
    checkOutput("postrst_acked", int'(got), 1);
    checkOutput("postrst_latency", cyc, 3);
    checkOutput("postrst_left", int'(qLeft), 270);
    checkOutput("postrst_right", int'(qRight), 333);
    @(posedge clk);
    #1 qReq = 1'b0;

    // A little more raster after the reset to re-exercise the model.
    speed = 3'd5;
    runFrame(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
